systolic_skew_feeder: RTL and testbench

//  Operand staging buffer directly upstream of the systolic array. Holds one DIMxDIM

---
 rtl/systolic_skew_feeder.sv | 138 +++++++++++++
 tb/tb_systolic_skew_feeder.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
// Operand staging buffer for one edge of a systolic array: holds a DIMxDIM tile written
// a row per cycle and streams it diagonally skewed, driving the array enable for the pass.
module systolic_skew_feeder #(
    parameter int BITS_AB   = 8,
    parameter int DIM       = 8,
    parameter bit TRANSPOSE = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DIM)-1:0]   wr_row,
    input  logic [DIM*BITS_AB-1:0]   wr_data,
    input  logic                     start,
    input  logic                     stall,
    output logic [DIM*BITS_AB-1:0]   lane_out,
    output logic                     arr_en,
    output logic                     busy,
    output logic                     done,
    output logic                     wr_err
);

    localparam int ROW_W    = $clog2(DIM);
    localparam int PASS_LEN = 3 * DIM - 2;
    localparam int CNT_W    = $clog2(PASS_LEN);
    localparam logic [CNT_W-1:0] LAST_T = CNT_W'(PASS_LEN - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               row_ok;
    logic               wr_ok;
    logic               err_set;
    logic [BITS_AB-1:0] tile [DIM][DIM];

    // Only meaningful when DIM is not a power of two; otherwise every row index is legal.
    assign row_ok = (int'(wr_row) < DIM);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        done      = 1'b0;
        arr_en    = 1'b0;
        wr_ok     = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                wr_ok   = wr_en && row_ok;
                err_set = wr_en && !row_ok;
                if (start) begin
                    state_nxt = STREAM;
                    cnt_nxt   = '0;
                end
            end
            STREAM: begin
                busy    = 1'b1;
                arr_en  = !stall;
                err_set = wr_en || start;
                if (!stall) begin
                    if (cnt == LAST_T) begin
                        state_nxt = DONE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                // Writes behave as in IDLE here; start is dropped without flagging.
                done      = 1'b1;
                wr_ok     = wr_en && row_ok;
                err_set   = wr_en && !row_ok;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            wr_err <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            if (err_set) begin
                wr_err <= 1'b1;
            end
        end
    end

    // NOTE: the tile is a register array, not a RAM, so it is cleared by reset and a
    // stream without a reload after reset yields zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    tile[r][c] <= '0;
                end
            end
        end else if (wr_ok) begin
            for (int c = 0; c < DIM; c++) begin
                tile[wr_row][c] <= wr_data[c*BITS_AB +: BITS_AB];
            end
        end
    end

    // Lane i shows diagonal element t-i; the extra diff bit keeps the window test exact.
    for (genvar i = 0; i < DIM; i++) begin : g_lane
        localparam logic [CNT_W-1:0] LANE_T = CNT_W'(i);
        logic [CNT_W:0]     diff;
        logic               in_win;
        logic [ROW_W-1:0]   k;
        logic [BITS_AB-1:0] lane_val;

        assign diff     = {1'b0, cnt} - {1'b0, LANE_T};
        assign in_win   = (cnt >= LANE_T) && (diff < (CNT_W+1)'(DIM));
        assign k        = diff[ROW_W-1:0];
        assign lane_val = (state == STREAM && in_win)
                        ? (TRANSPOSE ? tile[k][i] : tile[i][k])
                        : '0;
        assign lane_out[i*BITS_AB +: BITS_AB] = lane_val;
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: an A-edge and a B-edge instance (DIM=4) share
// stimulus; each scenario task compares outputs against hand values and a tile model.
module tb_systolic_skew_feeder;

    localparam int BITS_AB = 8;
    localparam int DIM     = 4;
    localparam int PASS    = 3 * DIM - 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [1:0]  wr_row;
    logic [31:0] wr_data;
    logic        start;
    logic        stall;
    logic [31:0] lane_a, lane_b;
    logic        en_a, en_b, busy_a, busy_b, done_a, done_b, err_a, err_b;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mdl [DIM][DIM];

    always #5 clk = ~clk;

    systolic_skew_feeder #(.BITS_AB(BITS_AB), .DIM(DIM), .TRANSPOSE(1'b0)) u_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
        .start(start), .stall(stall), .lane_out(lane_a), .arr_en(en_a),
        .busy(busy_a), .done(done_a), .wr_err(err_a)
    );

    systolic_skew_feeder #(.BITS_AB(BITS_AB), .DIM(DIM), .TRANSPOSE(1'b1)) u_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
        .start(start), .stall(stall), .lane_out(lane_b), .arr_en(en_b),
        .busy(busy_b), .done(done_b), .wr_err(err_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_vec(int t, bit tr);
        logic [31:0] v = '0;
        for (int i = 0; i < DIM; i++) begin
            int d = t - i;
            if (d >= 0 && d < DIM) v[i*8 +: 8] = tr ? mdl[d][i] : mdl[i][d];
        end
        return v;
    endfunction

    function automatic logic [7:0] lane_of(logic [31:0] v, int i);
        return v[i*8 +: 8];
    endfunction

    task automatic load_base;
        for (int r = 0; r < DIM; r++) begin
            wr_en  = 1'b1;
            wr_row = 2'(r);
            for (int c = 0; c < DIM; c++) begin
                mdl[r][c] = 8'(4 * r + c + 1);
                wr_data[c*8 +: 8] = 8'(4 * r + c + 1);
            end
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; wr_en = 1'b0; wr_row = '0; wr_data = '0; start = 1'b0; stall = 1'b0;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) mdl[r][c] = 8'h00;
        tick();
        tick();
        @(negedge clk);
        n_vec++;
        if ({lane_a, lane_b, en_a, busy_a, done_a, err_a} !== 68'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got lane_a=%h lane_b=%h en=%b busy=%b done=%b err=%b required all 0",
                     lane_a, lane_b, en_a, busy_a, done_a, err_a);
        end
        tick();
        rst = 1'b0;
        stall = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({lane_a, en_a, busy_a, done_a} !== 35'h0) begin
            n_err++;
            $display("FAIL idle_stall: got lane=%h en=%b busy=%b done=%b required all 0",
                     lane_a, en_a, busy_a, done_a);
        end
        tick();
        stall = 1'b0;
    endtask

    task automatic test_pass;
        int en_cnt = 0;
        load_base();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < PASS; t++) begin
            @(negedge clk);
            n_vec++;
            if (lane_a !== exp_vec(t, 1'b0)) begin
                n_err++; $display("FAIL pass_lane_a t=%0d: got %h required %h", t, lane_a, exp_vec(t, 1'b0));
            end
            n_vec++;
            if (lane_b !== exp_vec(t, 1'b1)) begin
                n_err++; $display("FAIL pass_lane_b t=%0d: got %h required %h", t, lane_b, exp_vec(t, 1'b1));
            end
            n_vec++;
            if ({busy_a, en_a, busy_b, en_b} !== 4'b1111) begin
                n_err++; $display("FAIL pass_busy_en t=%0d: got %b required 1111", t, {busy_a, en_a, busy_b, en_b});
            end
            if (en_a) en_cnt++;
            if (t == 0) begin
                n_vec++;
                if (lane_a !== 32'h0000_0001) begin
                    n_err++; $display("FAIL hand_a_t0: got %h required 00000001", lane_a);
                end
            end
            if (t == 1) begin
                n_vec++;
                if (lane_b !== 32'h0000_0205) begin
                    n_err++; $display("FAIL hand_b_t1: got %h required 00000205", lane_b);
                end
            end
            if (t == 3) begin
                n_vec++;
                if (lane_a !== 32'h0D0A_0704) begin
                    n_err++; $display("FAIL hand_a_t3: got %h required 0d0a0704", lane_a);
                end
                n_vec++;
                if (lane_b !== 32'h0407_0A0D) begin
                    n_err++; $display("FAIL hand_b_t3: got %h required 04070a0d", lane_b);
                end
            end
            if (t == 6) begin
                n_vec++;
                if (lane_a !== 32'h1000_0000) begin
                    n_err++; $display("FAIL hand_a_t6: got %h required 10000000", lane_a);
                end
            end
            tick();
        end
        @(negedge clk);
        n_vec++;
        if ({done_a, busy_a, en_a, done_b, busy_b} !== 5'b10010 || lane_a !== 32'h0) begin
            n_err++;
            $display("FAIL pass_done_cycle: got done=%b busy=%b en=%b lane=%h required done=1 busy=0 en=0 lane=0",
                     done_a, busy_a, en_a, lane_a);
        end
        n_vec++;
        if (en_cnt !== PASS) begin
            n_err++; $display("FAIL pass_en_count: got %0d required %0d", en_cnt, PASS);
        end
        tick();
        @(negedge clk);
        n_vec++;
        if ({done_a, busy_a, en_a} !== 3'b000) begin
            n_err++; $display("FAIL pass_after_done: got done/busy/en=%b required 000", {done_a, busy_a, en_a});
        end
        tick();
    endtask

    task automatic test_stall;
        int t = 0;
        int c = 0;
        int en_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (t < PASS && c < 40) begin
            stall = (c == 4 || c == 5);
            @(negedge clk);
            n_vec++;
            if (lane_a !== exp_vec(t, 1'b0) || en_a !== !stall || busy_a !== 1'b1) begin
                n_err++;
                $display("FAIL stall_cycle c=%0d: got lane=%h en=%b busy=%b required lane=%h en=%b busy=1",
                         c, lane_a, en_a, busy_a, exp_vec(t, 1'b0), !stall);
            end
            if (c == 5) begin
                n_vec++;
                if (lane_a !== 32'h0E0B_0800) begin
                    n_err++; $display("FAIL stall_hold_t4: got %h required 0e0b0800", lane_a);
                end
            end
            if (en_a) en_cnt++;
            tick();
            if (!stall) t++;
            c++;
        end
        stall = 1'b0;
        @(negedge clk);
        n_vec++;
        if (done_a !== 1'b1 || c !== PASS + 2) begin
            n_err++; $display("FAIL stall_done: got done=%b after %0d cycles required done=1 after %0d", done_a, c, PASS + 2);
        end
        n_vec++;
        if (en_cnt !== PASS) begin
            n_err++; $display("FAIL stall_en_count: got %0d required %0d", en_cnt, PASS);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        n_vec++;
        if (err_a !== 1'b0) begin
            n_err++; $display("FAIL b2b_err_clear: got %b required 0", err_a);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < PASS; t++) tick();
        start = 1'b1;
        @(negedge clk);
        n_vec++;
        if (done_a !== 1'b1) begin
            n_err++; $display("FAIL b2b_done: got %b required 1", done_a);
        end
        tick();
        @(negedge clk);
        n_vec++;
        if ({busy_a, en_a, done_a} !== 3'b000 || lane_a !== 32'h0) begin
            n_err++; $display("FAIL b2b_start_on_done: got busy/en/done=%b lane=%h required 000 lane 0",
                              {busy_a, en_a, done_a}, lane_a);
        end
        tick();
        start = 1'b0;
        for (int t = 0; t < PASS; t++) begin
            @(negedge clk);
            n_vec++;
            if (lane_a !== exp_vec(t, 1'b0) || lane_b !== exp_vec(t, 1'b1) || en_a !== 1'b1) begin
                n_err++; $display("FAIL b2b_pass t=%0d: got a=%h b=%h en=%b required a=%h b=%h en=1",
                                  t, lane_a, lane_b, en_a, exp_vec(t, 1'b0), exp_vec(t, 1'b1));
            end
            tick();
        end
        @(negedge clk);
        n_vec++;
        if (done_a !== 1'b1 || err_a !== 1'b0) begin
            n_err++; $display("FAIL b2b_end: got done=%b err=%b required done=1 err=0", done_a, err_a);
        end
        tick();
    endtask

    task automatic test_write_with_start;
        wr_en   = 1'b1;
        wr_row  = 2'd2;
        wr_data = 32'h8080_8080;
        start   = 1'b1;
        for (int c = 0; c < DIM; c++) mdl[2][c] = 8'h80;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        for (int t = 0; t < PASS; t++) begin
            wr_en   = (t == 5);
            wr_row  = 2'd1;
            wr_data = 32'h5555_5555;
            @(negedge clk);
            n_vec++;
            if (lane_a !== exp_vec(t, 1'b0)) begin
                n_err++; $display("FAIL wrs_lane t=%0d: got %h required %h", t, lane_a, exp_vec(t, 1'b0));
            end
            if (t == 2) begin
                n_vec++;
                if (lane_of(lane_a, 2) !== 8'h80 || lane_of(lane_a, 0) !== 8'd3) begin
                    n_err++; $display("FAIL wrs_neg_t2: got lane2=%h lane0=%h required lane2=80 lane0=03",
                                      lane_of(lane_a, 2), lane_of(lane_a, 0));
                end
            end
            if (t == 5) begin
                n_vec++;
                if (err_a !== 1'b0) begin
                    n_err++; $display("FAIL wrs_err_early: got %b required 0", err_a);
                end
            end
            if (t == 6) begin
                n_vec++;
                if (err_a !== 1'b1) begin
                    n_err++; $display("FAIL wrs_err_set: got %b required 1", err_a);
                end
            end
            tick();
        end
        wr_en = 1'b0;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < PASS; t++) begin
            @(negedge clk);
            n_vec++;
            if (lane_a !== exp_vec(t, 1'b0)) begin
                n_err++; $display("FAIL wrs_restream t=%0d: got %h required %h", t, lane_a, exp_vec(t, 1'b0));
            end
            if (t == 3) begin
                n_vec++;
                if (lane_a !== 32'h0D80_0704) begin
                    n_err++; $display("FAIL wrs_hand_t3: got %h required 0d800704", lane_a);
                end
            end
            tick();
        end
        @(negedge clk);
        n_vec++;
        if (done_a !== 1'b1 || err_a !== 1'b1) begin
            n_err++; $display("FAIL wrs_end: got done=%b err=%b required done=1 err=1", done_a, err_a);
        end
        tick();
    endtask

    task automatic test_reset_mid_stream;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 5; t++) tick();
        n_vec++;
        if (busy_a !== 1'b1 || lane_a !== exp_vec(5, 1'b0)) begin
            n_err++; $display("FAIL rmid_before: got busy=%b lane=%h required busy=1 lane=%h",
                              busy_a, lane_a, exp_vec(5, 1'b0));
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({lane_a, en_a, busy_a, done_a, err_a} !== 36'h0) begin
            n_err++; $display("FAIL rmid_async: got lane=%h en=%b busy=%b done=%b err=%b required all 0",
                              lane_a, en_a, busy_a, done_a, err_a);
        end
        tick();
        rst = 1'b0;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) mdl[r][c] = 8'h00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_vec++;
            if (done_a !== 1'b0 || busy_a !== 1'b0) begin
                n_err++; $display("FAIL rmid_no_done k=%0d: got done=%b busy=%b required 0 0", k, done_a, busy_a);
            end
            tick();
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < PASS; t++) begin
            @(negedge clk);
            n_vec++;
            if (lane_a !== 32'h0 || lane_b !== 32'h0 || en_a !== 1'b1) begin
                n_err++; $display("FAIL rmid_cleared t=%0d: got a=%h b=%h en=%b required a=0 b=0 en=1",
                                  t, lane_a, lane_b, en_a);
            end
            tick();
        end
        tick();
    endtask

    task automatic test_start_while_busy;
        load_base();
        n_vec++;
        if (err_a !== 1'b0) begin
            n_err++; $display("FAIL swb_err_clear: got %b required 0", err_a);
        end
        start = 1'b1;
        tick();
        for (int t = 0; t < PASS; t++) begin
            start = (t == 3);
            @(negedge clk);
            n_vec++;
            if (lane_a !== exp_vec(t, 1'b0) || lane_b !== exp_vec(t, 1'b1)) begin
                n_err++; $display("FAIL swb_lane t=%0d: got a=%h b=%h required a=%h b=%h",
                                  t, lane_a, lane_b, exp_vec(t, 1'b0), exp_vec(t, 1'b1));
            end
            if (t == 4) begin
                n_vec++;
                if (err_a !== 1'b1 || err_b !== 1'b1) begin
                    n_err++; $display("FAIL swb_err_set: got a=%b b=%b required 1 1", err_a, err_b);
                end
            end
            tick();
        end
        start = 1'b0;
        @(negedge clk);
        n_vec++;
        if (done_a !== 1'b1) begin
            n_err++; $display("FAIL swb_done: got %b required 1", done_a);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_pass();
        test_stall();
        test_back_to_back();
        test_write_with_start();
        test_reset_mid_stream();
        test_start_while_busy();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
